// File: rtl/ddr3_ref_arb.sv
// DDR3 command arbiter: configurator, refresh and controller FSM onto one DDL channel.
// Refreshes are counted, postponed up to REF_POSTPONE and drained back to back.
module ddr3_ref_arb #(
  parameter int          DDR_ROW_BITS = 13,
  parameter int          REF_LAZY     = 4,
  parameter int          REF_POSTPONE = 8,
  parameter logic [2:0]  CMD_REFR     = 3'b001,
  parameter logic [2:0]  CMD_NOOP     = 3'b111
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    cfg_run_i,
  input  logic                    cfg_req_i,
  output logic                    cfg_rdy_o,
  input  logic [2:0]              cfg_cmd_i,
  input  logic [2:0]              cfg_ba_i,
  input  logic [DDR_ROW_BITS-1:0] cfg_adr_i,
  input  logic                    cfg_ref_i,
  input  logic                    fsm_req_i,
  output logic                    fsm_rdy_o,
  input  logic [2:0]              fsm_cmd_i,
  input  logic [2:0]              fsm_ba_i,
  input  logic [DDR_ROW_BITS-1:0] fsm_adr_i,
  input  logic                    fsm_idle_i,
  output logic                    ctl_req_o,
  input  logic                    ctl_rdy_i,
  output logic [2:0]              ctl_cmd_o,
  output logic [2:0]              ctl_ba_o,
  output logic [DDR_ROW_BITS-1:0] ctl_adr_o,
  output logic                    ref_pend_o,
  output logic                    ref_urgent_o,
  output logic [3:0]              ref_cnt_o,
  output logic                    ref_err_o
);

  localparam logic [3:0] LAZY = 4'(REF_LAZY);
  localparam logic [3:0] POST = 4'(REF_POSTPONE);
  localparam logic [3:0] CMAX = 4'(REF_POSTPONE + 1);

  typedef enum logic [1:0] {
    ST_INIT,
    ST_FSM,
    ST_REFR
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_cnt;
  logic       r_err;
  logic       r_busy;
  logic [3:0] w_cnt_nxt;
  logic       w_err_set;
  logic       w_tick;
  logic       w_ref_hs;
  logic       w_block;
  logic       w_busy;

  assign ref_cnt_o    = r_cnt;
  assign ref_err_o    = r_err;
  assign ref_pend_o   = (r_cnt >= LAZY);
  assign ref_urgent_o = (r_cnt >= POST);

  // Only block once any FSM command already on the channel has been taken.
  assign w_block  = ref_urgent_o & ~r_busy;
  assign w_tick   = cfg_ref_i & (r_state != ST_INIT);
  assign w_ref_hs = (r_state == ST_REFR) & ctl_rdy_i;

  always_comb begin
    w_cnt_nxt = r_cnt;
    w_err_set = 1'b0;
    if (w_tick && !w_ref_hs) begin
      if (r_cnt >= CMAX) w_err_set = 1'b1;
      else               w_cnt_nxt = r_cnt + 4'd1;
    end else if (w_ref_hs && !w_tick && r_cnt != 4'd0) begin
      w_cnt_nxt = r_cnt - 4'd1;
    end
  end

  always_comb begin
    ctl_req_o   = cfg_req_i;
    ctl_cmd_o   = cfg_cmd_i;
    ctl_ba_o    = cfg_ba_i;
    ctl_adr_o   = cfg_adr_i;
    cfg_rdy_o   = 1'b0;
    fsm_rdy_o   = 1'b0;
    w_busy      = 1'b0;
    w_state_nxt = r_state;
    unique case (r_state)
      ST_INIT: begin
        cfg_rdy_o = ctl_rdy_i;
      end
      ST_FSM: begin
        ctl_req_o = fsm_req_i & ~w_block;
        ctl_cmd_o = w_block ? CMD_NOOP : fsm_cmd_i;
        ctl_ba_o  = fsm_ba_i;
        ctl_adr_o = fsm_adr_i;
        fsm_rdy_o = ctl_rdy_i & ~w_block;
      end
      ST_REFR: begin
        ctl_req_o = 1'b1;
        ctl_cmd_o = CMD_REFR;
        ctl_ba_o  = '0;
        ctl_adr_o = '0;
      end
      default: ;
    endcase
    w_busy = ctl_req_o & ~ctl_rdy_i;
    if (!cfg_run_i) begin
      if (!w_busy) w_state_nxt = ST_INIT;
    end else begin
      unique case (r_state)
        ST_INIT: if (!w_busy) w_state_nxt = ST_FSM;
        ST_FSM:
          if (ref_pend_o && fsm_idle_i && !fsm_req_i && !w_busy)
            w_state_nxt = ST_REFR;
        ST_REFR:
          if (w_ref_hs && w_cnt_nxt == 4'd0) w_state_nxt = ST_FSM;
        default: w_state_nxt = ST_INIT;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_INIT;
      r_cnt   <= 4'd0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= w_busy;
      r_err   <= r_err | w_err_set;
      if (r_state == ST_INIT || w_state_nxt == ST_INIT) r_cnt <= 4'd0;
      else                                              r_cnt <= w_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_ddr3_ref_arb.sv
// Bench for ddr3_ref_arb: vector table, corner sequences, random run vs model.
// The model tracks pending refreshes as a plain integer and arbiter mode.
module tb_ddr3_ref_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic        run, creq, crdy, tick, freq, frdy, idle;
  logic        req, rdy, pend, urg, err;
  logic [2:0]  ccmd, cba, fcmd, fba, cmd, ba;
  logic [12:0] cadr, fadr, adr;
  logic [3:0]  cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ddr3_ref_arb dut (
    .clock(clk), .reset(reset),
    .cfg_run_i(run), .cfg_req_i(creq), .cfg_rdy_o(crdy),
    .cfg_cmd_i(ccmd), .cfg_ba_i(cba), .cfg_adr_i(cadr),
    .cfg_ref_i(tick),
    .fsm_req_i(freq), .fsm_rdy_o(frdy), .fsm_cmd_i(fcmd),
    .fsm_ba_i(fba), .fsm_adr_i(fadr), .fsm_idle_i(idle),
    .ctl_req_o(req), .ctl_rdy_i(rdy), .ctl_cmd_o(cmd),
    .ctl_ba_o(ba), .ctl_adr_o(adr),
    .ref_pend_o(pend), .ref_urgent_o(urg),
    .ref_cnt_o(cnt), .ref_err_o(err)
  );

  // Reference model: mode 0 = configurator owns channel,
  // 1 = controller owns channel, 2 = draining refreshes.
  int   m_mode, m_pend;
  bit   m_err, m_stall;
  logic e_req, e_crdy, e_frdy;
  logic [2:0]  e_cmd, e_ba;
  logic [12:0] e_adr;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_pend = 0; m_err = 0; m_stall = 0;
  endtask

  task automatic eval();
    bit blk;
    @(negedge clk);
    e_crdy = 1'b0; e_frdy = 1'b0;
    if (m_mode == 0) begin
      e_req = creq; e_cmd = ccmd; e_ba = cba; e_adr = cadr; e_crdy = rdy;
    end else if (m_mode == 1) begin
      blk = (m_pend >= 8) && !m_stall;
      e_req = freq && !blk; e_cmd = blk ? 3'b111 : fcmd;
      e_ba = fba; e_adr = fadr; e_frdy = rdy && !blk;
    end else begin
      e_req = 1'b1; e_cmd = 3'b001; e_ba = 3'd0; e_adr = 13'd0;
    end
    chk("model",
        {3'b0, req, cmd, ba, adr, crdy, frdy, pend, urg, cnt, err},
        {3'b0, e_req, e_cmd, e_ba, e_adr, e_crdy, e_frdy,
         1'(m_pend >= 4), 1'(m_pend >= 8), 4'(m_pend), m_err});
  endtask

  task automatic adv();
    bit stall, done;
    int p, nm;
    if (reset) begin
      model_reset();
    end else begin
      stall = e_req && !rdy;
      done  = (m_mode == 2) && rdy;
      p = m_pend;
      if (m_mode != 0) begin
        if (tick && !done) begin
          if (p == 9) m_err = 1;
          else p++;
        end else if (done && !tick && p > 0) p--;
      end
      nm = m_mode;
      if (!run) begin
        if (!stall) nm = 0;
      end else if (m_mode == 0) begin
        if (!stall) nm = 1;
      end else if (m_mode == 1) begin
        if (m_pend >= 4 && idle && !freq && !stall) nm = 2;
      end else if (done && p == 0) nm = 1;
      if (nm == 0) p = 0;
      m_pend = p; m_mode = nm; m_stall = stall;
    end
    @(posedge clk); #1;
    cba = 3'($urandom); cadr = 13'($urandom);
    fba = 3'($urandom); fadr = 13'($urandom);
  endtask

  task automatic cyc();
    eval(); adv();
  endtask

  typedef struct {
    logic run, creq; logic [2:0] ccmd; logic tick, freq;
    logic [2:0] fcmd; logic idle, rdy;
    logic e_req; logic [2:0] e_cmd; logic e_crdy, e_frdy, e_pend;
    logic [3:0] e_cnt;
  } vec_t;

  vec_t tbl[20];

  function automatic vec_t mk(logic r, logic cq, logic [2:0] cc, logic t,
                              logic ry, logic q, logic [2:0] c, logic cr,
                              logic fr, logic pd, logic [3:0] n);
    vec_t v;
    v.run = r; v.creq = cq; v.ccmd = cc; v.tick = t; v.freq = 1'b0;
    v.fcmd = 3'b111; v.idle = 1'b1; v.rdy = ry;
    v.e_req = q; v.e_cmd = c; v.e_crdy = cr; v.e_frdy = fr;
    v.e_pend = pd; v.e_cnt = n;
    return v;
  endfunction

  initial begin
    int nref;
    // init pass-through: 3x MRS, ZQCL, 3 ticks ignored
    tbl[0]  = mk(0,1,3'd0,1,0, 1,3'd0,0,0,0,4'd0);
    tbl[1]  = mk(0,1,3'd0,0,1, 1,3'd0,1,0,0,4'd0);
    tbl[2]  = mk(0,1,3'd0,1,0, 1,3'd0,0,0,0,4'd0);
    tbl[3]  = mk(0,1,3'd0,0,1, 1,3'd0,1,0,0,4'd0);
    tbl[4]  = mk(0,1,3'd0,1,0, 1,3'd0,0,0,0,4'd0);
    tbl[5]  = mk(0,1,3'd0,0,1, 1,3'd0,1,0,0,4'd0);
    tbl[6]  = mk(0,1,3'd6,0,0, 1,3'd6,0,0,0,4'd0);
    tbl[7]  = mk(0,1,3'd6,0,1, 1,3'd6,1,0,0,4'd0);
    tbl[8]  = mk(1,0,3'd0,0,1, 0,3'd0,1,0,0,4'd0);
    // lazy drain with a tick colliding with a REF at count 3
    tbl[9]  = mk(1,0,3'd0,1,1, 0,3'd7,0,1,0,4'd0);
    tbl[10] = mk(1,0,3'd0,1,1, 0,3'd7,0,1,0,4'd1);
    tbl[11] = mk(1,0,3'd0,1,1, 0,3'd7,0,1,0,4'd2);
    tbl[12] = mk(1,0,3'd0,1,1, 0,3'd7,0,1,0,4'd3);
    tbl[13] = mk(1,0,3'd0,0,1, 0,3'd7,0,1,1,4'd4);
    tbl[14] = mk(1,0,3'd0,0,1, 1,3'd1,0,0,1,4'd4);
    tbl[15] = mk(1,0,3'd0,1,1, 1,3'd1,0,0,0,4'd3);
    tbl[16] = mk(1,0,3'd0,0,1, 1,3'd1,0,0,0,4'd3);
    tbl[17] = mk(1,0,3'd0,0,1, 1,3'd1,0,0,0,4'd2);
    tbl[18] = mk(1,0,3'd0,0,1, 1,3'd1,0,0,0,4'd1);
    tbl[19] = mk(1,0,3'd0,0,1, 0,3'd7,0,1,0,4'd0);

    reset = 1'b1; run = 0; creq = 0; ccmd = 0; tick = 0;
    freq = 0; fcmd = 3'b111; idle = 1; rdy = 0;
    cba = 0; cadr = 0; fba = 0; fadr = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    eval();
    chk("reset_state", {frdy, pend, urg, cnt, err}, 8'h00);
    adv();

    foreach (tbl[i]) begin
      run = tbl[i].run; creq = tbl[i].creq; ccmd = tbl[i].ccmd;
      tick = tbl[i].tick; freq = tbl[i].freq; fcmd = tbl[i].fcmd;
      idle = tbl[i].idle; rdy = tbl[i].rdy;
      eval();
      chk($sformatf("vec%0d", i), {req, cmd, crdy, frdy, pend, cnt},
          {tbl[i].e_req, tbl[i].e_cmd, tbl[i].e_crdy, tbl[i].e_frdy,
           tbl[i].e_pend, tbl[i].e_cnt});
      adv();
    end

    // deferral: FSM streams reads while 8 ticks arrive
    tick = 0; idle = 0; freq = 1; fcmd = 3'b101; rdy = 1;
    for (int i = 0; i < 8; i++) begin
      tick = 1; eval();
      chk("defer_pass", {req, cmd, frdy}, {1'b1, 3'b101, 1'b1});
      adv();
    end
    tick = 0; eval();
    chk("defer_block", {urg, frdy, req, cmd}, {3'b100, 3'b111});
    adv();
    idle = 1; freq = 0; nref = 0;
    for (int i = 0; i < 20; i++) begin
      eval();
      if (req && cmd == 3'b001 && rdy) nref++;
      adv();
    end
    chk("defer_refs", 32'(nref), 32'd8);
    chk("defer_cnt", {28'd0, cnt}, 32'd0);

    // outstanding ACT must survive the count reaching urgent
    idle = 0; freq = 0;
    for (int i = 0; i < 7; i++) begin
      tick = 1; cyc();
    end
    freq = 1; fcmd = 3'b011; rdy = 0; eval();
    chk("act_issue", {req, cmd}, {1'b1, 3'b011});
    adv();
    tick = 0;
    for (int i = 0; i < 3; i++) begin
      eval();
      chk("act_hold", {req, cmd, urg, frdy}, {1'b1, 3'b011, 2'b10});
      adv();
    end
    rdy = 1; eval();
    chk("act_accept", {req, cmd, frdy}, {1'b1, 3'b011, 1'b1});
    adv();
    eval();
    chk("act_blocked", {req, cmd, frdy}, {1'b0, 3'b111, 1'b0});
    adv();
    idle = 1; freq = 0;
    repeat (15) cyc();
    chk("act_drained", {28'd0, cnt}, 32'd0);

    // overflow: 10 ticks with the FSM never idle
    idle = 0;
    for (int i = 0; i < 10; i++) begin
      tick = 1; cyc();
    end
    tick = 0; eval();
    chk("ovf_flag", {err, cnt}, {1'b1, 4'd9});
    adv();
    repeat (4) cyc();
    eval();
    chk("ovf_sticky", {28'd0, err, urg, pend, 1'b0}, {28'd0, 4'b1110});
    adv();
    idle = 1; cyc();
    rdy = 0; eval();
    chk("refr_pending", {req, cmd}, {1'b1, 3'b001});
    adv();
    reset = 1; cyc();
    reset = 0; creq = 0; rdy = 1; eval();
    chk("reset_mid_refr", {req, cnt, err, frdy, crdy},
        {1'b0, 4'd0, 1'b0, 1'b0, 1'b1});
    adv();

    // randomised traffic against the model
    for (int i = 0; i < 4000; i++) begin
      run   = ($urandom_range(99) != 0);
      creq  = 1'($urandom);
      ccmd  = 3'($urandom);
      tick  = ($urandom_range(3) == 0);
      freq  = ($urandom_range(2) == 0);
      fcmd  = 3'($urandom);
      idle  = ($urandom_range(3) != 0);
      rdy   = ($urandom_range(2) != 0);
      reset = ($urandom_range(499) == 0);
      cyc();
    end
    reset = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
